chip_test_sequencer: RTL and testbench

- Sits above the per-chip tester FSMs (chip_7400 and siblings). Each tester has a Run/Done/RSLT/DISP_RSLT handshake; all testers share one physical socket through a pin mux.
- This block owns the socket. It sets the mux, starts one tester, collects its verdict, releases it, and reports the result.
- Manual mode tests the chip type on Chip_Sel. Auto mode sweeps every tester in index order to identify an unknown chip.

---
 rtl/chip_test_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_chip_test_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip_test_sequencer.sv
// Owns the shared tester socket: sets the pin mux, starts one chip tester at a time and reports the verdict.
// Manual mode tests Chip_Sel; auto mode sweeps every tester. Optional watchdog: define CHIP_SEQ_WDOG_EN.
module chip_test_sequencer #(
    parameter int unsigned NUM_CHIPS  = 4,
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned WDOG_CYC   = 1024
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 Start,
    input  logic                 Auto,
    input  logic [SEL_W-1:0]     Chip_Sel,
    input  logic                 Ack,
    output logic [NUM_CHIPS-1:0] Run,
    output logic [NUM_CHIPS-1:0] Disp_Rslt,
    input  logic [NUM_CHIPS-1:0] Done,
    input  logic [NUM_CHIPS-1:0] Rslt,
    output logic [SEL_W-1:0]     Mux_Sel,
    output logic                 Mux_En,
    output logic                 Busy,
    output logic                 Result_Valid,
    output logic                 Pass,
    output logic [SEL_W-1:0]     Id,
    output logic                 Timeout
);

    localparam int unsigned SCNT_W = 8;

    if (NUM_CHIPS < 1 || (1 << SEL_W) < NUM_CHIPS || SETTLE_CYC < 1 || SETTLE_CYC > 255 || WDOG_CYC < 1)
    begin : g_param_check
        $error("chip_test_sequencer: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_RUN,
        S_WAIT,
        S_RELEASE,
        S_NEXT,
        S_REPORT
    } state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    idx_q, idx_d;
    logic                auto_q, auto_d;
    logic                cap_q, cap_d;
    logic [SCNT_W-1:0]   settle_q, settle_d;
    logic                pass_d;
    logic [SEL_W-1:0]    id_d;
    logic                timeout_d;
    logic                wdog_hit;
    logic [NUM_CHIPS-1:0] idx_oh_c;

    assign idx_oh_c = NUM_CHIPS'(1) << idx_d;

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        auto_d    = auto_q;
        cap_d     = cap_q;
        settle_d  = settle_q;
        pass_d    = Pass;
        id_d      = Id;
        timeout_d = Timeout;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    auto_d    = Auto;
                    pass_d    = 1'b0;
                    id_d      = '0;
                    timeout_d = 1'b0;
                    settle_d  = '0;
                    if (Auto) begin
                        idx_d   = '0;
                        state_d = S_SETTLE;
                    end else begin
                        idx_d = Chip_Sel;
                        if (32'(Chip_Sel) >= NUM_CHIPS) begin
                            id_d    = Chip_Sel;
                            state_d = S_REPORT;
                        end else begin
                            state_d = S_SETTLE;
                        end
                    end
                end
            end

            S_SETTLE: begin
                if (settle_q == SCNT_W'(SETTLE_CYC - 1)) begin
                    state_d = S_RUN;
                end else begin
                    settle_d = settle_q + SCNT_W'(1);
                end
            end

            S_RUN: begin
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (Done[idx_q]) begin
                    cap_d   = Rslt[idx_q];
                    state_d = S_RELEASE;
                end else if (wdog_hit) begin
                    cap_d     = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = S_NEXT;
                end
            end

            S_RELEASE: begin
                if (!Done[idx_q]) begin
                    state_d = S_NEXT;
                end else if (wdog_hit) begin
                    cap_d     = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = S_NEXT;
                end
            end

            S_NEXT: begin
                if (!auto_q || cap_q) begin
                    pass_d  = cap_q;
                    id_d    = idx_q;
                    state_d = S_REPORT;
                end else if (32'(idx_q) == NUM_CHIPS - 1) begin
                    pass_d  = 1'b0;
                    id_d    = '0;
                    state_d = S_REPORT;
                end else begin
                    idx_d    = idx_q + SEL_W'(1);
                    settle_d = '0;
                    state_d  = S_SETTLE;
                end
            end

            S_REPORT: begin
                if (Ack) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and outputs, registered from the next state so they line up with it
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            idx_q        <= '0;
            auto_q       <= 1'b0;
            cap_q        <= 1'b0;
            settle_q     <= '0;
            Run          <= '0;
            Disp_Rslt    <= '0;
            Mux_Sel      <= '0;
            Mux_En       <= 1'b0;
            Busy         <= 1'b0;
            Result_Valid <= 1'b0;
            Pass         <= 1'b0;
            Id           <= '0;
            Timeout      <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            auto_q       <= auto_d;
            cap_q        <= cap_d;
            settle_q     <= settle_d;
            Run          <= (state_d == S_RUN) ? idx_oh_c : '0;
            Disp_Rslt    <= (state_d == S_RELEASE) ? idx_oh_c : '0;
            Mux_Sel      <= (state_d == S_SETTLE) ? idx_d : Mux_Sel;
            Mux_En       <= (state_d == S_SETTLE) || (state_d == S_RUN) ||
                            (state_d == S_WAIT)   || (state_d == S_RELEASE);
            Busy         <= (state_d != S_IDLE);
            Result_Valid <= (state_d == S_REPORT);
            Pass         <= pass_d;
            Id           <= id_d;
            Timeout      <= timeout_d;
        end
    end

`ifdef CHIP_SEQ_WDOG_EN
    localparam int unsigned WCNT_W = $clog2(WDOG_CYC + 1);

    logic [WCNT_W-1:0] wdog_q, wdog_d;

    // Counts cycles spent in WAIT/RELEASE; restarts on every state entry
    always_comb begin
        wdog_d = '0;
        if ((state_q == S_WAIT || state_q == S_RELEASE) && (state_d == state_q)) begin
            wdog_d = wdog_q + WCNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end

    assign wdog_hit = (wdog_q == WCNT_W'(WDOG_CYC - 1));
`else
    assign wdog_hit = 1'b0;
`endif

endmodule

// File: tb/tb_chip_test_sequencer.sv
// Bench for chip_test_sequencer: vector table, randomized sessions against a session-level
// model, and hand-written reset / handshake sequences. Behavioural testers drive Done/Rslt.
`timescale 1ns/1ps
module tb_chip_test_sequencer;

    localparam int unsigned NC = 4;
    localparam int unsigned SW = 2;
    localparam int unsigned SC = 4;
    localparam int unsigned WD = 16;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          start, auto_i, ack;
    logic [SW-1:0] chip_sel;
    logic [NC-1:0] Run, Disp_Rslt, Done, Rslt;
    logic [SW-1:0] Mux_Sel, Id;
    logic          Mux_En, Busy, Result_Valid, Pass, Timeout;

    chip_test_sequencer #(
        .NUM_CHIPS(NC), .SEL_W(SW), .SETTLE_CYC(SC), .WDOG_CYC(WD)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(start), .Auto(auto_i), .Chip_Sel(chip_sel),
        .Ack(ack), .Run(Run), .Disp_Rslt(Disp_Rslt), .Done(Done), .Rslt(Rslt),
        .Mux_Sel(Mux_Sel), .Mux_En(Mux_En), .Busy(Busy), .Result_Valid(Result_Valid),
        .Pass(Pass), .Id(Id), .Timeout(Timeout)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // ---------------- behavioural testers ----------------
    logic [NC-1:0] done_m, rslt_m, extra_done;
    assign Done = done_m | extra_done;
    assign Rslt = rslt_m | extra_done;

    int t_dly  [NC];   // negedges from seeing Run to raising Done (>=1)
    int t_hold [NC];   // negedges Done stays high after Disp_Rslt is seen
    bit t_pass [NC];
    bit t_hang [NC];   // never raises Done
    int ph     [NC];
    int cnt    [NC];

    initial begin
        done_m = '0;
        rslt_m = '0;
        for (int i = 0; i < NC; i++) begin ph[i] = 0; cnt[i] = 0; end
        forever begin
            @(negedge Clk);
            for (int i = 0; i < NC; i++) begin
                if (!Reset_n) begin
                    ph[i] = 0; done_m[i] = 1'b0; rslt_m[i] = 1'b0;
                end else begin
                    case (ph[i])
                        0: if (Run[i] && !t_hang[i]) begin cnt[i] = t_dly[i]; ph[i] = 1; end
                        1: begin
                            cnt[i]--;
                            if (cnt[i] <= 0) begin done_m[i] = 1'b1; rslt_m[i] = t_pass[i]; ph[i] = 2; end
                        end
                        2: if (Disp_Rslt[i]) begin cnt[i] = t_hold[i]; ph[i] = 3; end
                        default: ;
                    endcase
                    if (ph[i] == 3) begin
                        if (cnt[i] == 0) begin done_m[i] = 1'b0; rslt_m[i] = 1'b0; ph[i] = 0; end
                        else cnt[i]--;
                    end
                end
            end
        end
    end

    // ---------------- Run monitor ----------------
    int run_q [$];
    int run_at [$];
    int bad_mux = 0;
    int run_early = 0;

    function automatic int oh_idx(input logic [NC-1:0] v);
        int k;
        k = -1;
        for (int i = 0; i < NC; i++) if (v[i]) k = (k == -1) ? i : -2;
        return k;
    endfunction

    always @(negedge Clk) begin
        if (Run != '0) begin
            run_q.push_back(oh_idx(Run));
            run_at.push_back(cyc);
            if (!Mux_En || int'(Mux_Sel) != oh_idx(Run)) bad_mux++;
            if (done_m != '0) run_early++;
        end
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int            nruns;
        logic          pass;
        logic [SW-1:0] id;
        logic          tmo;
        int            lat;
    } exp_t;

    // Cost of one tester visit: settle, run pulse, wait, release, next
    function automatic int visit_cost(input int i);
        return SC + 2 + (t_hang[i] ? WD : t_dly[i] + t_hold[i] + 1);
    endfunction

    // Session-level reference: which testers get run, verdict and total latency
    function automatic exp_t model(input bit a, input int sel);
        exp_t e;
        e.nruns = 0; e.pass = 1'b0; e.id = '0; e.tmo = 1'b0; e.lat = 0;
        if (!a) begin
            e.nruns = 1;
            e.id    = SW'(sel);
            e.pass  = t_pass[sel] && !t_hang[sel];
            e.tmo   = t_hang[sel];
            e.lat   = visit_cost(sel);
        end else begin
            for (int i = 0; i < NC; i++) begin
                e.nruns++;
                e.lat += visit_cost(i);
                e.tmo |= t_hang[i];
                if (t_pass[i] && !t_hang[i]) begin
                    e.pass = 1'b1;
                    e.id   = SW'(i);
                    break;
                end
            end
        end
        return e;
    endfunction

    int t0;

    task automatic ack_check(input string tag, input exp_t e);
        @(negedge Clk); ack = 1'b1;
        @(negedge Clk); ack = 1'b0;
        chk({tag, " busy_after_ack"}, 32'(Busy), 0);
        chk({tag, " rv_after_ack"}, 32'(Result_Valid), 0);
        chk({tag, " pass_held"}, 32'(Pass), 32'(e.pass));
        chk({tag, " id_held"}, 32'(Id), 32'(e.id));
        chk({tag, " timeout_held"}, 32'(Timeout), 32'(e.tmo));
    endtask

    task automatic session(input string tag, input bit a, input int sel, input exp_t e, input bit do_ack);
        int n, q0, bm0, re0, nr, lat, expi;
        bit order_ok;
        @(negedge Clk);
        q0 = run_q.size(); bm0 = bad_mux; re0 = run_early;
        auto_i = a; chip_sel = SW'(sel); start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        t0 = cyc;
        n = 0;
        while (!Result_Valid && n < 4000) begin @(negedge Clk); n++; end
        chk({tag, " result_valid"}, 32'(Result_Valid), 1);
        if (!Result_Valid) return;
        lat = cyc - t0;
        nr  = run_q.size() - q0;
        chk({tag, " latency"}, lat, e.lat);
        chk({tag, " pass"}, 32'(Pass), 32'(e.pass));
        chk({tag, " id"}, 32'(Id), 32'(e.id));
        chk({tag, " timeout"}, 32'(Timeout), 32'(e.tmo));
        chk({tag, " busy_report"}, 32'(Busy), 1);
        chk({tag, " mux_en_report"}, 32'(Mux_En), 0);
        chk({tag, " run_count"}, nr, e.nruns);
        order_ok = 1'b1;
        for (int k = 0; k < nr; k++) begin
            expi = a ? k : sel;
            if (run_q[q0 + k] != expi) order_ok = 1'b0;
        end
        chk({tag, " run_order"}, 32'(order_ok), 1);
        chk({tag, " first_run_offset"}, (run_at.size() > q0) ? run_at[q0] - t0 : -1, SC);
        chk({tag, " mux_sel_final"}, 32'(Mux_Sel), a ? e.nruns - 1 : sel);
        chk({tag, " mux_at_run"}, bad_mux - bm0, 0);
        chk({tag, " run_before_release"}, run_early - re0, 0);
        if (do_ack) ack_check(tag, e);
    endtask

    task automatic set_uniform(input logic [NC-1:0] p, input int dly, input int hold);
        for (int i = 0; i < NC; i++) begin
            t_pass[i] = p[i]; t_dly[i] = dly; t_hold[i] = hold; t_hang[i] = 1'b0;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit            a;
        int            sel;
        logic [NC-1:0] pass;
        int            dly;
        int            hold;
        exp_t          e;
    } vec_t;

    function automatic vec_t mkv(input bit a, input int sel, input logic [NC-1:0] p, input int dly,
                                 input int hold, input int nr, input bit ps, input int id, input int lat);
        vec_t v;
        v.a = a; v.sel = sel; v.pass = p; v.dly = dly; v.hold = hold;
        v.e.nruns = nr; v.e.pass = ps; v.e.id = SW'(id); v.e.tmo = 1'b0; v.e.lat = lat;
        return v;
    endfunction

    vec_t vt [7];

    initial begin
        exp_t e;
        bit   a;
        int   s, n0;

        vt[0] = mkv(1'b0, 2, 4'b0100, 10, 0, 1, 1'b1, 2, 17);
        vt[1] = mkv(1'b1, 0, 4'b0100,  2, 0, 3, 1'b1, 2, 27);
        vt[2] = mkv(1'b1, 0, 4'b0000,  1, 3, 4, 1'b0, 0, 44);
        vt[3] = mkv(1'b0, 1, 4'b1101,  3, 3, 1, 1'b0, 1, 13);
        vt[4] = mkv(1'b1, 0, 4'b1000,  1, 1, 4, 1'b1, 3, 36);
        vt[5] = mkv(1'b1, 0, 4'b0011,  1, 0, 1, 1'b1, 0,  8);
        vt[6] = mkv(1'b0, 3, 4'b1000,  5, 2, 1, 1'b1, 3, 14);

        Reset_n = 1'b0; start = 1'b0; auto_i = 1'b0; chip_sel = '0; ack = 1'b0; extra_done = '0;
        set_uniform('0, 1, 0);
        repeat (3) @(negedge Clk);
        chk("reset_outputs", 32'({Run, Disp_Rslt, Mux_Sel, Mux_En, Busy, Result_Valid, Pass, Id, Timeout}), 0);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("idle_after_reset", 32'({Busy, Result_Valid, Mux_En}), 0);

        for (int v = 0; v < 7; v++) begin
            set_uniform(vt[v].pass, vt[v].dly, vt[v].hold);
            session($sformatf("vec%0d", v), vt[v].a, vt[v].sel, vt[v].e, 1'b1);
        end

        // Done/Rslt of a non-selected tester must not end the wait
        set_uniform(4'b0010, 8, 0);
        extra_done = 4'b1000;
        session("other_done", 1'b0, 1, model(1'b0, 1), 1'b1);
        extra_done = '0;

        // Start ignored in REPORT; Ack wins over a simultaneous Start
        set_uniform(4'b0001, 2, 1);
        e = model(1'b0, 0);
        session("ack_prio", 1'b0, 0, e, 1'b0);
        n0 = run_q.size();
        @(negedge Clk); start = 1'b1; auto_i = 1'b1;
        repeat (3) @(negedge Clk);
        chk("start_in_report rv", 32'(Result_Valid), 1);
        chk("start_in_report runs", run_q.size() - n0, 0);
        ack = 1'b1;
        @(negedge Clk); ack = 1'b0; start = 1'b0;
        chk("ack_and_start busy", 32'(Busy), 0);
        @(negedge Clk);
        chk("ack_and_start still_idle", 32'({Busy, Mux_En}), 0);
        chk("ack_and_start no_run", run_q.size() - n0, 0);

        // Asynchronous reset while waiting on a tester
        set_uniform(4'b0100, 3, 0);
        t_hang[3] = 1'b1;
        @(negedge Clk); auto_i = 1'b0; chip_sel = 2'd3; start = 1'b1;
        @(negedge Clk); start = 1'b0;
        repeat (6) @(negedge Clk);
        chk("pre_reset busy/mux", 32'({Busy, Mux_En, Mux_Sel}), 32'({1'b1, 1'b1, 2'd3}));
        Reset_n = 1'b0;
        #1;
        chk("async_reset outputs", 32'({Run, Disp_Rslt, Mux_Sel, Mux_En, Busy, Result_Valid, Pass, Id, Timeout}), 0);
        @(negedge Clk); Reset_n = 1'b1;
        t_hang[3] = 1'b0;
        session("after_reset", 1'b0, 2, model(1'b0, 2), 1'b1);

`ifdef CHIP_SEQ_WDOG_EN
        set_uniform('0, 2, 0);
        t_hang[0] = 1'b1;
        session("wdog_manual", 1'b0, 0, model(1'b0, 0), 1'b1);
        set_uniform(4'b0100, 2, 1);
        t_hang[1] = 1'b1;
        session("wdog_auto", 1'b1, 0, model(1'b1, 0), 1'b1);
`endif

        // Randomized sessions against the model
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < NC; i++) begin
                t_pass[i] = ($urandom_range(0, 3) == 0);
                t_dly[i]  = int'($urandom_range(1, 6));
                t_hold[i] = int'($urandom_range(0, 3));
                t_hang[i] = 1'b0;
`ifdef CHIP_SEQ_WDOG_EN
                t_hang[i] = ($urandom_range(0, 7) == 0);
`endif
            end
            a = 1'($urandom_range(0, 1));
            s = int'($urandom_range(0, NC - 1));
            session($sformatf("rand%0d", r), a, s, model(a, s), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got no end of test, expected finish");
        $fatal(1, "time limit");
    end

endmodule
